// File: rtl/duck_game_pkg.sv
// Shared types and constants for the duck-hunt round sequencer.
package duck_game_pkg;

  typedef enum logic [2:0] {
    IDLE, INTRO, LAUNCH, FLY, FLEE, SHOW, TALLY, OVER
  } round_state_t;

  typedef enum logic [1:0] {
    SHOW_NONE     = 2'd0,
    SHOW_RETRIEVE = 2'd1,
    SHOW_LAUGH    = 2'd2
  } dog_show_t;

  localparam int unsigned        SCORE_W   = 20;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/duck_round_sequencer_if.sv
// Game-event bus between the round sequencer and dog / duck / hit-detect logic.
interface duck_round_sequencer_if;
  import duck_game_pkg::*;

  logic               frame_tick;
  logic               start;
  logic               intro_done;
  logic               shot;
  logic               shot_hit;
  logic               duck_gone;
  logic               show_done;
  logic               Run;
  logic               duck_launch;
  logic               duck_flee;
  logic [1:0]         dog_show;
  logic [3:0]         round;
  logic [3:0]         duck_idx;
  logic [1:0]         shots_left;
  logic [9:0]         hit_mask;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  modport master (
    output frame_tick, start, intro_done, shot, shot_hit, duck_gone, show_done,
    input  Run, duck_launch, duck_flee, dog_show, round, duck_idx, shots_left,
           hit_mask, score, game_over
  );

  modport slave (
    input  frame_tick, start, intro_done, shot, shot_hit, duck_gone, show_done,
    output Run, duck_launch, duck_flee, dog_show, round, duck_idx, shots_left,
           hit_mask, score, game_over
  );

endinterface

// File: rtl/duck_round_sequencer_flyaway_timer.sv
// Frame-tick counter for the duck fly-away timeout; holds at terminal count.
module flyaway_timer #(
  parameter int unsigned FLYAWAY_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic tick_i,
  output logic tc_o
);

  localparam int unsigned   CW   = $clog2(FLYAWAY_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(FLYAWAY_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (tick_i && (cnt_q != LAST))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/duck_round_sequencer.sv
// Round scheduler: dog intro, N duck launches with shot/timeout handling, tally.
// Optional PERFECT_BONUS_EN adds a bonus when every duck of a round is hit.
module duck_round_sequencer
  import duck_game_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned SHOTS_PER_DUCK  = 3,
  parameter int unsigned FLYAWAY_TICKS   = 50,
  parameter int unsigned PASS_COUNT      = 6,
  parameter int unsigned HIT_POINTS      = 500
) (
  input logic                    Clk,
  input logic                    Reset,
  duck_round_sequencer_if.slave  io
);

  localparam logic [3:0]         LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [SCORE_W-1:0] HIT_INC   = SCORE_W'(HIT_POINTS);

  round_state_t       state_q, state_d;
  dog_show_t          dog_show_q, dog_show_d;
  logic [3:0]         round_q, round_d;
  logic [3:0]         duck_idx_q, duck_idx_d;
  logic [1:0]         shots_left_q, shots_left_d;
  logic [9:0]         hit_mask_q, hit_mask_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   hit_sum;
  logic [3:0]         hit_cnt;
  logic               timer_tc;

`ifdef PERFECT_BONUS_EN
  localparam logic [SCORE_W-1:0] BONUS_INC = SCORE_W'(10000);
  localparam logic [9:0]         ALL_HIT   = 10'((32'd1 << DUCKS_PER_ROUND) - 32'd1);
  logic [SCORE_W:0] bonus_sum;
  assign bonus_sum = {1'b0, score_q} + {1'b0, BONUS_INC};
`endif

  assign hit_sum = {1'b0, score_q} + {1'b0, HIT_INC};

  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < 10; i++)
      hit_cnt = hit_cnt + {3'b000, hit_mask_q[i]};
  end

  flyaway_timer #(.FLYAWAY_TICKS(FLYAWAY_TICKS)) u_timer (
    .clk    (Clk),
    .rst    (Reset),
    .clr_i  (state_q == LAUNCH),
    .tick_i ((state_q == FLY) && io.frame_tick),
    .tc_o   (timer_tc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    dog_show_d   = dog_show_q;
    round_d      = round_q;
    duck_idx_d   = duck_idx_q;
    shots_left_d = shots_left_q;
    hit_mask_d   = hit_mask_q;
    score_d      = score_q;
    case (state_q)
      IDLE, OVER: if (io.start) begin
        state_d    = INTRO;
        score_d    = '0;
        round_d    = 4'd1;
        hit_mask_d = '0;
        duck_idx_d = '0;
      end
      INTRO: if (io.intro_done) state_d = LAUNCH;
      LAUNCH: begin
        shots_left_d = 2'(SHOTS_PER_DUCK);
        state_d      = FLY;
      end
      FLY: begin
        // A hit duck is falling: later shots and the timeout are ignored until it lands.
        if (dog_show_q == SHOW_RETRIEVE) begin
          if (io.duck_gone) state_d = SHOW;
        end else if (io.shot && io.shot_hit) begin
          hit_mask_d[duck_idx_q] = 1'b1;
          score_d    = hit_sum[SCORE_W] ? SCORE_MAX : hit_sum[SCORE_W-1:0];
          dog_show_d = SHOW_RETRIEVE;
        end else if (io.shot) begin
          shots_left_d = shots_left_q - 2'd1;
          if (shots_left_q == 2'd1) begin
            state_d    = FLEE;
            dog_show_d = SHOW_LAUGH;
          end
        end else if (io.frame_tick && timer_tc) begin
          state_d    = FLEE;
          dog_show_d = SHOW_LAUGH;
        end
      end
      FLEE: if (io.duck_gone) state_d = SHOW;
      SHOW: if (io.show_done) begin
        dog_show_d = SHOW_NONE;
        if (duck_idx_q == LAST_DUCK) begin
          state_d = TALLY;
        end else begin
          duck_idx_d = duck_idx_q + 4'd1;
          state_d    = LAUNCH;
        end
      end
      TALLY: begin
        if (hit_cnt >= 4'(PASS_COUNT)) begin
          round_d    = (round_q == 4'hF) ? round_q : round_q + 4'd1;
          hit_mask_d = '0;
          duck_idx_d = '0;
          state_d    = INTRO;
`ifdef PERFECT_BONUS_EN
          if (hit_mask_q == ALL_HIT)
            score_d = bonus_sum[SCORE_W] ? SCORE_MAX : bonus_sum[SCORE_W-1:0];
`endif
        end else begin
          state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dog_show_q   <= SHOW_NONE;
      round_q      <= 4'd1;
      duck_idx_q   <= '0;
      shots_left_q <= '0;
      hit_mask_q   <= '0;
      score_q      <= '0;
    end else begin
      dog_show_q   <= dog_show_d;
      round_q      <= round_d;
      duck_idx_q   <= duck_idx_d;
      shots_left_q <= shots_left_d;
      hit_mask_q   <= hit_mask_d;
      score_q      <= score_d;
    end
  end

  always_comb begin
    io.Run         = (state_q == INTRO);
    io.duck_launch = (state_q == LAUNCH);
    io.duck_flee   = (state_q == FLEE);
    io.game_over   = (state_q == OVER);
    io.dog_show    = dog_show_q;
    io.round       = round_q;
    io.duck_idx    = duck_idx_q;
    io.shots_left  = shots_left_q;
    io.hit_mask    = hit_mask_q;
    io.score       = score_q;
  end

endmodule

// File: tb/tb_duck_round_sequencer.sv
// Directed bench for duck_round_sequencer: vector table plus multi-cycle round sequences.
module tb_duck_round_sequencer;
  import duck_game_pkg::*;

  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_TICK  = 7'b1000000;
  localparam logic [6:0] I_START = 7'b0100000;
  localparam logic [6:0] I_INTRO = 7'b0010000;
  localparam logic [6:0] I_SHOT  = 7'b0001000;
  localparam logic [6:0] I_HIT   = 7'b0000100;
  localparam logic [6:0] I_GONE  = 7'b0000010;
  localparam logic [6:0] I_DONE  = 7'b0000001;

`ifdef PERFECT_BONUS_EN
  localparam int EXP_PERFECT = 15000;
`else
  localparam int EXP_PERFECT = 5000;
`endif

  typedef struct {
    logic [6:0]  in;
    logic        run;
    logic        launch;
    logic        flee;
    logic [1:0]  dog;
    logic [1:0]  shots;
    logic [3:0]  idx;
    logic [9:0]  mask;
    logic [19:0] score;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[17];

  always #5 Clk = ~Clk;

  duck_round_sequencer_if bus();

  duck_round_sequencer #(
    .DUCKS_PER_ROUND(10),
    .SHOTS_PER_DUCK (3),
    .FLYAWAY_TICKS  (50),
    .PASS_COUNT     (6),
    .HIT_POINTS     (500)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {bus.frame_tick, bus.start, bus.intro_done, bus.shot, bus.shot_hit,
     bus.duck_gone, bus.show_done} = in;
    @(posedge Clk);
    #1;
  endtask

  task automatic run_round(input logic [9:0] hits);
    drive(I_INTRO);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rr%0d.launch", i), 32'(bus.duck_launch), 1);
      drive(I_NONE);
      check($sformatf("rr%0d.launch_off", i), 32'(bus.duck_launch), 0);
      check($sformatf("rr%0d.idx", i), 32'(bus.duck_idx), i);
      check($sformatf("rr%0d.shots", i), 32'(bus.shots_left), 3);
      if (hits[i]) begin
        drive(I_SHOT | I_HIT);
        check($sformatf("rr%0d.dog", i), 32'(bus.dog_show), 1);
      end else begin
        repeat (3) drive(I_SHOT);
        check($sformatf("rr%0d.flee", i), 32'(bus.duck_flee), 1);
      end
      drive(I_GONE);
      drive(I_DONE);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           in                    run launch flee dog shots idx mask     score
    vecs[0]  = '{I_START,               1, 0, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[1]  = '{I_NONE,                1, 0, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[2]  = '{I_NONE,                1, 0, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[3]  = '{I_NONE,                1, 0, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[4]  = '{I_NONE,                1, 0, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[5]  = '{I_INTRO,               0, 1, 0, 2'd0, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[6]  = '{I_NONE,                0, 0, 0, 2'd0, 2'd3, 4'd0, 10'h000, 20'd0};
    vecs[7]  = '{I_SHOT,                0, 0, 0, 2'd0, 2'd2, 4'd0, 10'h000, 20'd0};
    vecs[8]  = '{I_SHOT,                0, 0, 0, 2'd0, 2'd1, 4'd0, 10'h000, 20'd0};
    vecs[9]  = '{I_SHOT,                0, 0, 1, 2'd2, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[10] = '{I_SHOT|I_HIT|I_GONE,   0, 0, 0, 2'd2, 2'd0, 4'd0, 10'h000, 20'd0};
    vecs[11] = '{I_SHOT|I_HIT|I_DONE,   0, 1, 0, 2'd0, 2'd0, 4'd1, 10'h000, 20'd0};
    vecs[12] = '{I_NONE,                0, 0, 0, 2'd0, 2'd3, 4'd1, 10'h000, 20'd0};
    vecs[13] = '{I_SHOT|I_HIT,          0, 0, 0, 2'd1, 2'd3, 4'd1, 10'h002, 20'd500};
    vecs[14] = '{I_SHOT|I_HIT|I_TICK,   0, 0, 0, 2'd1, 2'd3, 4'd1, 10'h002, 20'd500};
    vecs[15] = '{I_GONE,                0, 0, 0, 2'd1, 2'd3, 4'd1, 10'h002, 20'd500};
    vecs[16] = '{I_DONE,                0, 1, 0, 2'd0, 2'd3, 4'd2, 10'h002, 20'd500};

    Reset = 1'b1;
    {bus.frame_tick, bus.start, bus.intro_done, bus.shot, bus.shot_hit,
     bus.duck_gone, bus.show_done} = I_NONE;
    repeat (2) @(posedge Clk);
    #1;
    check("rst.run",       32'(bus.Run),         0);
    check("rst.launch",    32'(bus.duck_launch), 0);
    check("rst.flee",      32'(bus.duck_flee),   0);
    check("rst.dog",       32'(bus.dog_show),    0);
    check("rst.round",     32'(bus.round),       1);
    check("rst.score",     32'(bus.score),       0);
    check("rst.game_over", 32'(bus.game_over),   0);
    Reset = 1'b0;

    // Intro, three misses, ignored shots outside FLY, one hit.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].in);
      check($sformatf("v%0d.run", i),    32'(bus.Run),         32'(vecs[i].run));
      check($sformatf("v%0d.launch", i), 32'(bus.duck_launch), 32'(vecs[i].launch));
      check($sformatf("v%0d.flee", i),   32'(bus.duck_flee),   32'(vecs[i].flee));
      check($sformatf("v%0d.dog", i),    32'(bus.dog_show),    32'(vecs[i].dog));
      check($sformatf("v%0d.shots", i),  32'(bus.shots_left),  32'(vecs[i].shots));
      check($sformatf("v%0d.idx", i),    32'(bus.duck_idx),    32'(vecs[i].idx));
      check($sformatf("v%0d.mask", i),   32'(bus.hit_mask),    32'(vecs[i].mask));
      check($sformatf("v%0d.score", i),  32'(bus.score),       32'(vecs[i].score));
    end

    // Timeout: flee exactly on the 50th frame tick.
    drive(I_NONE);
    repeat (49) drive(I_TICK);
    check("to49.flee", 32'(bus.duck_flee), 0);
    drive(I_TICK);
    check("to50.flee", 32'(bus.duck_flee), 1);
    check("to50.dog",  32'(bus.dog_show),  2);
    drive(I_GONE);
    drive(I_DONE);
    check("to.idx", 32'(bus.duck_idx), 3);

    // Hit on the timeout tick wins over the timeout.
    drive(I_NONE);
    repeat (49) drive(I_TICK);
    drive(I_TICK | I_SHOT | I_HIT);
    check("tohit.flee",  32'(bus.duck_flee), 0);
    check("tohit.dog",   32'(bus.dog_show),  1);
    check("tohit.score", 32'(bus.score),     1000);
    check("tohit.mask",  32'(bus.hit_mask),  32'h00A);
    drive(I_TICK);
    check("tohit.noflee", 32'(bus.duck_flee), 0);

    // Asynchronous reset during FLY.
    #2;
    Reset = 1'b1;
    #1;
    check("arst.dog",   32'(bus.dog_show),   0);
    check("arst.score", 32'(bus.score),      0);
    check("arst.mask",  32'(bus.hit_mask),   0);
    check("arst.round", 32'(bus.round),      1);
    check("arst.idx",   32'(bus.duck_idx),   0);
    check("arst.shots", 32'(bus.shots_left), 0);
    @(posedge Clk);
    #1;
    check("arst.launch", 32'(bus.duck_launch), 0);
    check("arst.run",    32'(bus.Run),         0);
    Reset = 1'b0;
    drive(I_NONE);
    check("idle.run", 32'(bus.Run), 0);

    // Round pass with 6 hits, then fail with 5 hits, then restart.
    drive(I_START);
    check("g1.run", 32'(bus.Run), 1);
    run_round(10'h03F);
    check("g1.tally_mask",  32'(bus.hit_mask), 32'h03F);
    check("g1.tally_score", 32'(bus.score),    3000);
    check("g1.tally_run",   32'(bus.Run),      0);
    drive(I_NONE);
    check("g1.round", 32'(bus.round),    2);
    check("g1.mask",  32'(bus.hit_mask), 0);
    check("g1.idx",   32'(bus.duck_idx), 0);
    check("g1.run2",  32'(bus.Run),      1);
    run_round(10'h01F);
    check("g2.tally_score", 32'(bus.score), 5500);
    drive(I_NONE);
    check("g2.over",  32'(bus.game_over), 1);
    check("g2.round", 32'(bus.round),     2);
    drive(I_NONE);
    check("g2.over_hold", 32'(bus.game_over), 1);
    drive(I_START);
    check("g3.over",  32'(bus.game_over), 0);
    check("g3.score", 32'(bus.score),     0);
    check("g3.round", 32'(bus.round),     1);
    check("g3.mask",  32'(bus.hit_mask),  0);
    check("g3.run",   32'(bus.Run),       1);

    // Perfect round.
    run_round(10'h3FF);
    drive(I_NONE);
    check("perf.score", 32'(bus.score), EXP_PERFECT);
    check("perf.round", 32'(bus.round), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
